// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : display_pkg
// Description : Shared constants and types for the LEDR/HEX mode selector.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Active-low seven-segment pattern with every segment dark
  localparam logic [7:0] HEX_BLANK = 8'hFF;

  // Defaults for a 50 MHz board clock: 10 ms debounce, 50 ms blanking
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_BLANK_CYCLES    = 2500000;

  // Display state: showing a mode's data, or dark while switching
  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } disp_state_e;

endpackage : display_pkg
`default_nettype wire

// File: rtl/mode_display_mux_if.sv
`default_nettype none
// ============================================================================
// Interface   : mode_display_mux_if
// Description : Mode-select inputs, per-mode display buses and the selected
//               LEDR/HEX outputs of the mode display multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mode_display_mux_if #(
  parameter int NUM_MODES  = 4,
  parameter int LED_W      = 10,
  parameter int HEX_DIGITS = 6
);

  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic [MODE_W-1:0]               sel_direct;
  logic                            sel_load;
  logic [NUM_MODES*LED_W-1:0]      mode_led;
  logic [NUM_MODES*HEX_DIGITS*8-1:0] mode_hex;
  logic [LED_W-1:0]                LEDR;
  logic [HEX_DIGITS*8-1:0]         HEX;
  logic [MODE_W-1:0]               mode;
  logic                            switching;

  // Driver side: supplies requests and sub-unit data, observes outputs
  modport master (
    output sel_direct, sel_load, mode_led, mode_hex,
    input  LEDR, HEX, mode, switching
  );

  // Multiplexer side
  modport slave (
    input  sel_direct, sel_load, mode_led, mode_hex,
    output LEDR, HEX, mode, switching
  );

endinterface : mode_display_mux_if
`default_nettype wire

// File: rtl/mode_display_mux_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises a raw active-low pushbutton, filters bounce with
//               a stability counter and emits a one-cycle pulse per press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic key_n,
  output logic      press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             press_q, press_d;

  // Filter: the level follows the synchronised key only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; agreement resets count.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;   // only the 1->0 (press) edge is reported
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, debounced level, stability counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/mode_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : mode_display_mux
// Description : Selects one of NUM_MODES LED/HEX sets for the board displays.
//               Mode advances on a debounced key press or loads directly;
//               each change is followed by a timed blanking interval.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_display_mux
  import display_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int LED_W           = 10,
  parameter int HEX_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES
) (
  input  wire logic         MAX10_CLK1_50,
  input  wire logic         RESET_N,
  input  wire logic         KEY_NEXT,
  mode_display_mux_if.slave bus
);

  localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int BCNT_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int HEX_W   = HEX_DIGITS * 8;
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [BCNT_W-1:0] BCNT_START = BCNT_W'(BLANK_CYCLES - 1);

  logic press_pulse;

  disp_state_e       state_q, state_d;
  logic [MODE_W-1:0] mode_q,  mode_d;
  logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
  logic [LED_W-1:0]  led_q,   led_d;
  logic [HEX_W-1:0]  hex_q,   hex_d;
  logic              sw_q,    sw_d;

  logic              req_valid;
  logic [MODE_W-1:0] req_mode;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk         (MAX10_CLK1_50),
    .rst_n       (RESET_N),
    .key_n       (KEY_NEXT),
    .press_pulse (press_pulse)
  );

  // Request arbitration: a load always wins the cycle, even when its index
  // is out of range (the whole cycle is then dropped); requests only count
  // while showing.
  always_comb begin
    req_valid = 1'b0;
    req_mode  = mode_q;
    if (state_q == SHOW) begin
      if (bus.sel_load) begin
        if (32'(bus.sel_direct) < NUM_MODES) begin
          req_valid = 1'b1;
          req_mode  = bus.sel_direct;
        end
      end else if (press_pulse) begin
        req_valid = 1'b1;
        req_mode  = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
      end
    end
  end

  // Next-state: accepted requests update the mode and start blanking
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      SHOW: begin
        if (req_valid) begin
          mode_d = req_mode;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            bcnt_d  = BCNT_START;
          end
        end
      end
      BLANK: begin
        if (bcnt_q == '0) begin
          state_d = SHOW;
        end else begin
          bcnt_d = bcnt_q - BCNT_W'(1);
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // Outputs: follow the next state/mode so the displays go dark on the same
  // edge that changes the mode, and the new data lands the edge blank ends.
  always_comb begin
    led_d = '0;
    hex_d = {HEX_DIGITS{HEX_BLANK}};
    sw_d  = 1'b1;
    if (state_d == SHOW) begin
      led_d = bus.mode_led[32'(mode_d) * LED_W +: LED_W];
      hex_d = bus.mode_hex[32'(mode_d) * HEX_W +: HEX_W];
      sw_d  = 1'b0;
    end
  end

  // State, mode, blank counter and output registers
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SHOW;
      mode_q  <= '0;
      bcnt_q  <= '0;
      led_q   <= '0;
      hex_q   <= {HEX_DIGITS{HEX_BLANK}};
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bcnt_q  <= bcnt_d;
      led_q   <= led_d;
      hex_q   <= hex_d;
      sw_q    <= sw_d;
    end
  end

  assign bus.LEDR      = led_q;
  assign bus.HEX       = hex_q;
  assign bus.mode      = mode_q;
  assign bus.switching = sw_q;

endmodule : mode_display_mux
`default_nettype wire

// File: tb/tb_mode_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_display_mux
// Description : Directed self-checking bench for mode_display_mux
//               (3 modes, 4-cycle debounce, 3-cycle blanking).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_display_mux;

  localparam int NM = 3;
  localparam int LW = 10;
  localparam int HD = 6;

  typedef struct {
    string       tag;
    logic [9:0]  led;
    logic [47:0] hex;
    logic [1:0]  mode;
    logic        sw;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic sw_seen;

  localparam logic [47:0] ALL_FF = 48'hFFFF_FFFF_FFFF;

  mode_display_mux_if #(.NUM_MODES(NM), .LED_W(LW), .HEX_DIGITS(HD)) bus ();

  mode_display_mux #(
    .NUM_MODES       (NM),
    .LED_W           (LW),
    .HEX_DIGITS      (HD),
    .DEBOUNCE_CYCLES (4),
    .BLANK_CYCLES    (3)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .RESET_N       (rst_n),
    .KEY_NEXT      (key),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] hx(input int m);
    logic [7:0] d;
    d = 8'h10 + 8'(m);
    return {6{d}};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [9:0] led,
                            input logic [47:0] hex, input logic [1:0] m,
                            input logic sw);
    exp_t e;
    e.tag = tag; e.led = led; e.hex = hex; e.mode = m; e.sw = sw;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries required >0");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 4;
      assert (bus.LEDR === e.led) else begin
        errors++;
        $error("FAIL %s.LEDR: observed %h required %h", e.tag, bus.LEDR, e.led);
      end
      assert (bus.HEX === e.hex) else begin
        errors++;
        $error("FAIL %s.HEX: observed %h required %h", e.tag, bus.HEX, e.hex);
      end
      assert (bus.mode === e.mode) else begin
        errors++;
        $error("FAIL %s.mode: observed %0d required %0d", e.tag, bus.mode, e.mode);
      end
      assert (bus.switching === e.sw) else begin
        errors++;
        $error("FAIL %s.switching: observed %b required %b", e.tag, bus.switching, e.sw);
      end
    end
  endtask

  task automatic clean_press();
    key = 1'b0;
    step(10);
    key = 1'b1;
    step(10);
  endtask

  task automatic load(input logic [1:0] idx);
    bus.sel_direct = idx;
    bus.sel_load   = 1'b1;
    step(1);
    bus.sel_load   = 1'b0;
  endtask

  initial begin
    bus.sel_direct = '0;
    bus.sel_load   = 1'b0;
    bus.mode_led   = {10'd3, 10'd2, 10'd1};
    bus.mode_hex   = {hx(2), hx(1), hx(0)};

    // Reset held, then released
    step(2);
    expect_out("rst_hold", 10'd0, ALL_FF, 2'd0, 1'b0);
    check_out();
    rst_n = 1'b1;
    expect_out("rst_release", 10'd1, hx(0), 2'd0, 1'b0);
    step(1);
    check_out();

    // Clean press: sync 2 + debounce 4 -> pulse, mode/blank on the next edge
    key = 1'b0;
    expect_out("press_pre", 10'd1, hx(0), 2'd0, 1'b0);
    step(6);
    check_out();
    expect_out("press_blank1", 10'd0, ALL_FF, 2'd1, 1'b1);
    step(1);
    check_out();
    expect_out("press_blank3", 10'd0, ALL_FF, 2'd1, 1'b1);
    step(2);
    check_out();
    expect_out("press_show", 10'd2, hx(1), 2'd1, 1'b0);
    step(1);
    check_out();
    key = 1'b1;
    step(10);

    // Bounce: toggling every 2 cycles never stays stable long enough
    sw_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key = ~key;
      for (int j = 0; j < 2; j++) begin
        step(1);
        if (bus.switching !== 1'b0) sw_seen = 1'b1;
      end
    end
    step(8);
    checks++;
    assert (sw_seen === 1'b0) else begin
      errors++;
      $error("FAIL bounce_blank: observed %b required 0", sw_seen);
    end
    expect_out("bounce", 10'd2, hx(1), 2'd1, 1'b0);
    check_out();

    // Back to mode 0 by direct load, then three presses wrap 1, 2, 0
    expect_out("load0_blank", 10'd0, ALL_FF, 2'd0, 1'b1);
    load(2'd0);
    check_out();
    expect_out("load0_show", 10'd1, hx(0), 2'd0, 1'b0);
    step(3);
    check_out();
    for (int k = 1; k <= 3; k++) begin
      expect_out($sformatf("wrap%0d", k), 10'(k % 3 + 1), hx(k % 3), 2'(k % 3), 1'b0);
      clean_press();
      check_out();
    end

    // Direct load of index 2
    expect_out("load2_blank1", 10'd0, ALL_FF, 2'd2, 1'b1);
    load(2'd2);
    check_out();
    expect_out("load2_blank3", 10'd0, ALL_FF, 2'd2, 1'b1);
    step(2);
    check_out();
    expect_out("load2_show", 10'd3, hx(2), 2'd2, 1'b0);
    step(1);
    check_out();

    // Out-of-range load is ignored without blanking
    expect_out("load3_now", 10'd3, hx(2), 2'd2, 1'b0);
    load(2'd3);
    check_out();
    expect_out("load3_later", 10'd3, hx(2), 2'd2, 1'b0);
    step(3);
    check_out();

    // Collision: load 0 coincides with a press from mode 1 -> load wins
    load(2'd1);
    step(3);
    expect_out("coll_mode1", 10'd2, hx(1), 2'd1, 1'b0);
    check_out();
    key = 1'b0;
    step(6);
    expect_out("coll_blank", 10'd0, ALL_FF, 2'd0, 1'b1);
    load(2'd0);
    check_out();
    expect_out("coll_show", 10'd1, hx(0), 2'd0, 1'b0);
    step(3);
    check_out();
    key = 1'b1;
    step(10);

    // Press debounced while blanking is dropped
    key = 1'b0;
    step(4);
    expect_out("drop_blank1", 10'd0, ALL_FF, 2'd2, 1'b1);
    load(2'd2);
    check_out();
    expect_out("drop_blank3", 10'd0, ALL_FF, 2'd2, 1'b1);
    step(2);
    check_out();
    expect_out("drop_show", 10'd3, hx(2), 2'd2, 1'b0);
    step(1);
    check_out();
    step(2);
    key = 1'b1;
    step(10);
    expect_out("drop_after", 10'd3, hx(2), 2'd2, 1'b0);
    check_out();

    // Reset asserted on the second blank cycle
    expect_out("rstmid_blank1", 10'd0, ALL_FF, 2'd1, 1'b1);
    load(2'd1);
    check_out();
    step(1);
    rst_n = 1'b0;
    #1;
    expect_out("rstmid_async", 10'd0, ALL_FF, 2'd0, 1'b0);
    check_out();
    step(2);
    rst_n = 1'b1;
    expect_out("rstmid_release", 10'd1, hx(0), 2'd0, 1'b0);
    step(1);
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mode_display_mux
`default_nettype wire
